// File: rtl/cla_result_serializer.sv
// Serializes one registered CLA result word (sum plus carry-out) onto a single
// wire, holding each bit for BIT_CYCLES clocks, with a one-cycle done pulse.
module cla_result_serializer #(
  parameter int WIDTH      = 9,
  parameter int BIT_CYCLES = 4,
  parameter int LSB_FIRST  = 1
) (
  input  logic             clk,
  input  logic             Rs,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             frame_done,
  output logic             busy,
  output logic [1:0]       dbg_state_o
);

  // Handshake: a word moves on a rising edge where load_valid and load_ready
  // are both 1; load_ready is a pure function of state, never of load_valid.

  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
  localparam logic [CW-1:0] CYC_LAST = CW'(BIT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic [CW-1:0]    cyc_q, cyc_d;

  always_ff @(posedge clk or posedge Rs) begin
    if (Rs) begin
      state_q <= S_IDLE;
      shreg_q <= '0;
      bit_q   <= '0;
      cyc_q   <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      bit_q   <= bit_d;
      cyc_q   <= cyc_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    bit_d      = bit_q;
    cyc_d      = cyc_q;
    load_ready = 1'b0;
    ser_out    = 1'b0;
    ser_valid  = 1'b0;
    frame_done = 1'b0;
    busy       = 1'b0;
    case (state_q)
      S_IDLE: begin
        load_ready = 1'b1;
        if (load_valid) begin
          shreg_d = data_in;
          bit_d   = '0;
          cyc_d   = '0;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        busy      = 1'b1;
        ser_valid = 1'b1;
        // The outgoing bit always sits at one end; the register shifts toward it.
        ser_out   = (LSB_FIRST != 0) ? shreg_q[0] : shreg_q[WIDTH-1];
        if (cyc_q == CYC_LAST) begin
          cyc_d = '0;
          if (bit_q == BIT_LAST) begin
            state_d = S_DONE;
          end else begin
            bit_d   = bit_q + 1'b1;
            shreg_d = (LSB_FIRST != 0) ? (shreg_q >> 1) : (shreg_q << 1);
          end
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end
      S_DONE: begin
        busy       = 1'b1;
        frame_done = 1'b1;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_cla_result_serializer.sv
// Directed bench: default LSB-first / 4-cycle instance plus an MSB-first
// one-cycle-per-bit instance, checked against hand-computed bit sequences.
module tb_cla_result_serializer;

  logic       clk = 1'b0;
  logic       Rs;
  logic [8:0] din_a, din_b;
  logic       lv_a, lv_b;
  logic       rdy_a, out_a, val_a, done_a, busy_a;
  logic       rdy_b, out_b, val_b, done_b, busy_b;
  logic [1:0] st_a, st_b;

  int total = 0;
  int bad   = 0;
  logic [0:0] exp_q[$];

  // clock / reset block
  always #5 clk = ~clk;

  cla_result_serializer u_dut (
    .clk(clk), .Rs(Rs), .data_in(din_a), .load_valid(lv_a),
    .load_ready(rdy_a), .ser_out(out_a), .ser_valid(val_a),
    .frame_done(done_a), .busy(busy_a), .dbg_state_o(st_a)
  );

  cla_result_serializer #(.WIDTH(9), .BIT_CYCLES(1), .LSB_FIRST(0)) u_msb (
    .clk(clk), .Rs(Rs), .data_in(din_b), .load_valid(lv_b),
    .load_ready(rdy_b), .ser_out(out_b), .ser_valid(val_b),
    .frame_done(done_b), .busy(busy_b), .dbg_state_o(st_b)
  );

  // Inputs change and outputs are sampled 1 ns after each rising edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    Rs = 1'b1; lv_a = 1'b0; lv_b = 1'b0; din_a = '0; din_b = '0;
    #1;
    total++;
    if ({rdy_a, out_a, val_a, done_a, busy_a, st_a} !== 7'b1000000) begin
      bad++;
      $display("FAIL reset_a got rdy/out/val/done/busy/st=%b exp=1000000",
               {rdy_a, out_a, val_a, done_a, busy_a, st_a});
    end
    total++;
    if ({rdy_b, out_b, val_b, done_b, busy_b, st_b} !== 7'b1000000) begin
      bad++;
      $display("FAIL reset_b got rdy/out/val/done/busy/st=%b exp=1000000",
               {rdy_b, out_b, val_b, done_b, busy_b, st_b});
    end
    tick; tick;
    Rs = 1'b0;
    tick;
  endtask

  task automatic test_basic;
    logic [8:0] w;
    w = 9'h1A5;
    lv_a = 1'b1; din_a = w;
    tick;
    lv_a = 1'b0; din_a = '0;
    total++;
    if (rdy_a !== 1'b0) begin
      bad++; $display("FAIL basic_ready_busy got %b exp 0", rdy_a);
    end
    for (int c = 1; c <= 36; c++) begin
      total++;
      if (val_a !== 1'b1 || out_a !== w[(c-1)/4] || busy_a !== 1'b1) begin
        bad++;
        $display("FAIL basic_bit c=%0d got val=%b out=%b busy=%b exp val=1 out=%b busy=1",
                 c, val_a, out_a, busy_a, w[(c-1)/4]);
      end
      tick;
    end
    total++;
    if ({done_a, val_a, out_a, busy_a, rdy_a} !== 5'b10010) begin
      bad++;
      $display("FAIL basic_done got done/val/out/busy/rdy=%b exp 10010",
               {done_a, val_a, out_a, busy_a, rdy_a});
    end
    tick;
    total++;
    if ({rdy_a, done_a, busy_a, val_a} !== 4'b1000) begin
      bad++;
      $display("FAIL basic_idle got rdy/done/busy/val=%b exp 1000",
               {rdy_a, done_a, busy_a, val_a});
    end
  endtask

  task automatic test_msb_first;
    logic [8:0] w;
    w = 9'h0C3;
    lv_b = 1'b1; din_b = w;
    tick;
    lv_b = 1'b0; din_b = '0;
    for (int c = 1; c <= 9; c++) begin
      total++;
      if (val_b !== 1'b1 || out_b !== w[9-c]) begin
        bad++;
        $display("FAIL msb_bit c=%0d got val=%b out=%b exp val=1 out=%b",
                 c, val_b, out_b, w[9-c]);
      end
      tick;
    end
    total++;
    if ({done_b, val_b, out_b, busy_b} !== 4'b1001) begin
      bad++;
      $display("FAIL msb_done got done/val/out/busy=%b exp 1001",
               {done_b, val_b, out_b, busy_b});
    end
    tick;
    total++;
    if ({rdy_b, busy_b} !== 2'b10) begin
      bad++; $display("FAIL msb_idle got rdy/busy=%b exp 10", {rdy_b, busy_b});
    end
  endtask

  task automatic test_back_to_back;
    logic [0:0] e;
    exp_q.delete();
    for (int i = 0; i < 36; i++) exp_q.push_back(1'b1);
    for (int i = 0; i < 36; i++) exp_q.push_back(1'b0);
    lv_a = 1'b1; din_a = 9'h1FF;
    tick;
    for (int c = 1; c <= 37; c++) begin
      if (c == 5) din_a = 9'h000;
      if (c <= 36) begin
        e = exp_q.pop_front();
        total++;
        if (val_a !== 1'b1 || out_a !== e[0]) begin
          bad++;
          $display("FAIL b2b_first c=%0d got val=%b out=%b exp val=1 out=%b",
                   c, val_a, out_a, e[0]);
        end
      end else begin
        total++;
        if ({done_a, rdy_a} !== 2'b10) begin
          bad++; $display("FAIL b2b_done got done/rdy=%b exp 10", {done_a, rdy_a});
        end
      end
      tick;
    end
    total++;
    if ({rdy_a, busy_a} !== 2'b10) begin
      bad++; $display("FAIL b2b_gap got rdy/busy=%b exp 10", {rdy_a, busy_a});
    end
    tick;
    lv_a = 1'b0;
    for (int c = 1; c <= 36; c++) begin
      e = exp_q.pop_front();
      total++;
      if (val_a !== 1'b1 || out_a !== e[0] || rdy_a !== 1'b0) begin
        bad++;
        $display("FAIL b2b_second c=%0d got val=%b out=%b rdy=%b exp val=1 out=%b rdy=0",
                 c, val_a, out_a, rdy_a, e[0]);
      end
      tick;
    end
    total++;
    if (done_a !== 1'b1) begin
      bad++; $display("FAIL b2b_second_done got %b exp 1", done_a);
    end
    tick;
  endtask

  task automatic test_reset_mid_frame;
    logic [8:0] w;
    lv_a = 1'b1; din_a = 9'h1A5;
    tick;
    lv_a = 1'b0;
    for (int c = 1; c < 18; c++) tick;
    total++;
    if ({val_a, out_a, busy_a} !== 3'b101) begin
      bad++; $display("FAIL rst_pre got val/out/busy=%b exp 101", {val_a, out_a, busy_a});
    end
    #2 Rs = 1'b1;
    #1;
    total++;
    if ({rdy_a, out_a, val_a, done_a, busy_a, st_a} !== 7'b1000000) begin
      bad++;
      $display("FAIL rst_async got rdy/out/val/done/busy/st=%b exp 1000000",
               {rdy_a, out_a, val_a, done_a, busy_a, st_a});
    end
    lv_a = 1'b1; din_a = 9'h001;
    tick;
    total++;
    if ({rdy_a, done_a, busy_a, val_a} !== 4'b1000) begin
      bad++;
      $display("FAIL rst_load_blocked got rdy/done/busy/val=%b exp 1000",
               {rdy_a, done_a, busy_a, val_a});
    end
    Rs = 1'b0;
    tick;
    lv_a = 1'b0; din_a = '0;
    w = 9'h001;
    for (int c = 1; c <= 36; c++) begin
      total++;
      if (val_a !== 1'b1 || out_a !== w[(c-1)/4] || done_a !== 1'b0) begin
        bad++;
        $display("FAIL rst_reload c=%0d got val=%b out=%b done=%b exp val=1 out=%b done=0",
                 c, val_a, out_a, done_a, w[(c-1)/4]);
      end
      tick;
    end
    total++;
    if (done_a !== 1'b1) begin
      bad++; $display("FAIL rst_reload_done got %b exp 1", done_a);
    end
    tick;
  endtask

  task automatic test_ignored_load;
    logic [8:0] w;
    w = 9'h1A5;
    lv_a = 1'b1; din_a = w;
    tick;
    lv_a = 1'b0; din_a = '0;
    for (int c = 1; c <= 36; c++) begin
      if (c == 10) begin lv_a = 1'b1; din_a = 9'h0AA; end
      if (c == 11) begin lv_a = 1'b0; din_a = '0; end
      total++;
      if (val_a !== 1'b1 || out_a !== w[(c-1)/4]) begin
        bad++;
        $display("FAIL ign_bit c=%0d got val=%b out=%b exp val=1 out=%b",
                 c, val_a, out_a, w[(c-1)/4]);
      end
      tick;
    end
    total++;
    if (done_a !== 1'b1) begin
      bad++; $display("FAIL ign_done got %b exp 1", done_a);
    end
    tick;
    for (int c = 0; c < 10; c++) begin
      total++;
      if ({val_a, busy_a, rdy_a} !== 3'b001) begin
        bad++;
        $display("FAIL ign_no_resend c=%0d got val/busy/rdy=%b exp 001",
                 c, {val_a, busy_a, rdy_a});
      end
      tick;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_msb_first();
    test_back_to_back();
    test_reset_mid_frame();
    test_ignored_load();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cla_result_serializer.md
CLA_RESULT_SERIALIZER -- requirements
Module: cla_result_serializer

Interface
REQ-001 The module SHALL have parameter WIDTH, default 9, giving the number of bits per frame (8-bit CLA sum plus carry-out).
REQ-002 The module SHALL have parameter BIT_CYCLES, default 4, giving the number of clk cycles each serial bit is held (legal range 1..255).
REQ-003 The module SHALL have parameter LSB_FIRST, default 1: 1 = bit 0 is sent first, 0 = bit WIDTH-1 is sent first.
REQ-004 clk  input  1  the single clock; all state SHALL change on its rising edge only.
REQ-005 Rs  input  1  reset, asynchronous and active-high.
REQ-006 data_in  input  WIDTH  registered CLA result to transmit.
REQ-007 load_valid  input  1  producer offers data_in.
REQ-008 load_ready  output  1  serializer can accept a word.
REQ-009 ser_out  output  1  serial data bit.
REQ-010 ser_valid  output  1  ser_out carries a frame bit.
REQ-011 frame_done  output  1  one-cycle pulse after the last bit.
REQ-012 busy  output  1  a frame is in progress (SHIFT or DONE state).

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, SHIFT and DONE.
REQ-014 In IDLE, load_ready SHALL be 1; in SHIFT and DONE, load_ready SHALL be 0.
REQ-015 A load SHALL be accepted only on a rising edge where load_valid=1 and load_ready=1.
- At that edge, data_in SHALL be captured into the shift register.
- At that edge, the bit counter SHALL clear, the cycle counter SHALL clear, and the state SHALL become SHIFT.
REQ-016 Latency: the first frame bit SHALL appear on ser_out with ser_valid=1 in the cycle immediately after the accepting edge.
REQ-017 In SHIFT, each bit SHALL be held on ser_out for exactly BIT_CYCLES cycles, then the next bit SHALL be presented in the order set by LSB_FIRST.
REQ-018 ser_valid SHALL be 1 for exactly WIDTH*BIT_CYCLES consecutive cycles per frame.
REQ-019 After the last cycle of bit WIDTH-1 the state SHALL become DONE for exactly one cycle.
- In DONE: frame_done=1, ser_valid=0, ser_out=0, busy=1.
- The state SHALL then become IDLE.
REQ-020 The next load SHALL be acceptable no earlier than the edge ending the first IDLE cycle after DONE. The minimum frame-to-frame spacing SHALL be WIDTH*BIT_CYCLES+2 cycles.
REQ-021 While state is not IDLE:
- load_valid and data_in SHALL be ignored.
- Changes on data_in SHALL NOT affect the frame in progress.
REQ-022 Outside SHIFT, ser_out SHALL be 0 and ser_valid SHALL be 0.
REQ-023 Counter widths SHALL hold WIDTH-1 and BIT_CYCLES-1 without overflow. No counter SHALL wrap within a frame.
REQ-024 With BIT_CYCLES=1, the block SHALL present one bit per cycle with no idle gaps between bits.

Reset
REQ-025 While Rs=1, independent of clk, the following SHALL hold immediately:
- state IDLE, shift register 0, both counters 0;
- load_ready=1, ser_out=0, ser_valid=0, frame_done=0, busy=0.
REQ-026 When Rs is asserted mid-frame, the frame SHALL be abandoned with no frame_done pulse. After Rs deasserts, the first rising edge SHALL be able to accept a new load.
REQ-027 A load presented on the edge at which Rs is 1 SHALL NOT be accepted.

Verification
REQ-028 Basic frame: WIDTH=9, BIT_CYCLES=4, LSB_FIRST=1; load 9'h1A5 -> ser_out sequence 1,0,1,0,0,1,0,1,1, each bit held 4 cycles; ser_valid high for 36 cycles; frame_done high in cycle 37; load_ready=1 in cycle 38.
REQ-029 MSB-first: LSB_FIRST=0, BIT_CYCLES=1; load 9'h0C3 -> ser_out sequence 0,1,1,0,0,0,0,1,1 on 9 consecutive cycles, then frame_done.
REQ-030 Back-to-back: hold load_valid=1 with 9'h1FF then 9'h000 -> second word accepted exactly 38 cycles after the first; first frame all ones; data_in change mid-frame has no effect on it.
REQ-031 Reset mid-frame: assert Rs asynchronously during bit 4 of 9'h1A5 -> all outputs reach reset values before the next clk edge; no frame_done; load of 9'h001 after release yields 1,0,0,0,0,0,0,0,0.
REQ-032 Ignored load: pulse load_valid with 9'h0AA during SHIFT -> no effect on the current frame; the word is not transmitted later.
